watch_btn_sched: RTL and testbench
==================================

# watch_btn_sched

Button scheduler and mode controller for the world-clock watch datapath. Debounces five raw push-buttons and arbitrates adjust requests into single-cycle increment pulses, one per cycle, in fixed priority. Holds each pulse off the cycle of the 1 Hz second tick so an adjustment can never mask a timekeeping update. Owns the time/alarm `set` mode bit, with optional auto-repeat for hour and minute adjust.

## Interface
- DEB_CYCLES, 1000000: consecutive stable cycles before a debounced level changes (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000: hold cycles after a debounced rise before the first auto-repeat.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeats.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low.
- btn_nara, btn_day, btn_hour, btn_min, btn_mode  in  1 each  raw button levels, active-high, asynchronous to clk.
- tick  in  1  one-cycle second-advance strobe from the timekeeping counter.
- set  out  1  0 = time-set mode, 1 = alarm-set mode.
- inc_nara, inc_day, inc_hour, inc_min  out  1 each  one-cycle increment pulses to the watch datapath.
- busy  out  1  OR of all pending flags.

## Operation
- Sync: each btn passes through a 2-flop synchronizer before its debouncer.
- Debounce: per-button counter. When the synchronized level differs from the debounced level `db`, the counter increments. Otherwise it clears. On reaching DEB_CYCLES-1, `db` takes the new level and the counter clears. A debounced 0->1 transition is a press event. Releases generate nothing.
- Pending flags pend_nara, pend_day, pend_hour, pend_min:
  - A press event sets the flag.
  - A second press before issue is absorbed, not counted.
  - In set=1, presses on nara and day are discarded and their flags are never set.
- Mode: a btn_mode press toggles `set`. The same edge clears pend_hour and pend_min, so a queued adjust never lands on the wrong target. pend_nara and pend_day also clear when `set` goes to 1.
- Arbiter: purely combinational from registered flags.
  - When tick=0, exactly one inc_* is asserted for the highest-priority set flag. Priority order is nara > day > hour > min.
  - The issued flag clears at the end of that cycle.
  - When tick=1, all inc_* are 0 and flags hold.
- Press event and issue of the same flag in the same cycle: the flag remains set, so one further pulse follows.
- Mode press and hour/min issue in the same cycle: the pulse is still issued under the old `set`. Clearing applies to flags that remain.
- Reset mid-operation: every counter, `db`, flag and `set` clear asynchronously. Outputs drop to 0 immediately.

## Timing
- Reset values: set=0, all inc_*=0, busy=0.
- Press latency: a raw rise held stable reaches `db` after 2 sync cycles + DEB_CYCLES. The pend flag sets on the following edge. inc_* is high in the next cycle with tick=0.
- Issue rate: at most one inc pulse per cycle. Four simultaneous flags drain in 4 tick-free cycles.
- inc_* is never high in a cycle with tick=1.
- `set` changes on the clock edge after the btn_mode debounced rise.

## Configuration
- WATCH_AUTO_REPEAT_EN defined:
  - While db_hour (or db_min) stays 1, its repeat counter runs from the press event.
  - At REPEAT_DELAY it sets the pend flag, then again every REPEAT_PERIOD cycles.
  - Release, a mode toggle, or reset clears the counter.
  - Repeat is active in both `set` modes.
- Undefined: the repeat counters are absent and each press yields exactly one pulse. nara, day and mode never repeat in either build.

## Test plan
Bench parameters: DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset, then btn_min held high 10 cycles -> exactly one inc_min pulse, 7 cycles after the rise (2 sync + 4 debounce + 1). set=0, busy drops with the pulse.
- btn_hour bounces 1/0 every 2 cycles for 12 cycles, then holds 0 -> no inc_hour pulse.
- btn_nara, btn_day, btn_hour, btn_min rise together, tick=0 -> inc_nara, inc_day, inc_hour, inc_min on 4 consecutive cycles. With tick=1 on the second of those cycles, inc_day slips one cycle and no pulse appears in the tick cycle.
- btn_mode press -> set=1. A following btn_day press gives no inc_day. btn_min press gives inc_min. A second mode press returns set=0.
- btn_hour pressed, btn_mode pressed while tick held 1 -> pend_hour cleared, no inc_hour after tick falls.
- With WATCH_AUTO_REPEAT_EN, btn_min held 60 cycles -> inc_min at press+1, then 20 and 28 cycles after the press event, repeating every 8 until release. Without it, exactly one pulse.

Source files
------------

// File: rtl/watch_btn_sched_if.sv
// Button-scheduler bus: raw buttons and the second tick in, mode bit,
// increment pulses and busy out.
//   i_btn_nara/day/hour/min/mode : raw active-high buttons (async to clock)
//   i_tick                       : one-cycle second-advance strobe
//   o_set                        : 0 = time-set mode, 1 = alarm-set mode
//   o_inc_nara/day/hour/min      : one-cycle increment pulses
//   o_busy                       : any adjust request still pending
// slave modport = scheduler side, master modport = the side driving buttons.
interface watch_btn_sched_if;
  logic i_btn_nara;
  logic i_btn_day;
  logic i_btn_hour;
  logic i_btn_min;
  logic i_btn_mode;
  logic i_tick;
  logic o_set;
  logic o_inc_nara;
  logic o_inc_day;
  logic o_inc_hour;
  logic o_inc_min;
  logic o_busy;

  modport slave (
    input  i_btn_nara, i_btn_day, i_btn_hour, i_btn_min, i_btn_mode, i_tick,
    output o_set, o_inc_nara, o_inc_day, o_inc_hour, o_inc_min, o_busy
  );

  modport master (
    output i_btn_nara, i_btn_day, i_btn_hour, i_btn_min, i_btn_mode, i_tick,
    input  o_set, o_inc_nara, o_inc_day, o_inc_hour, o_inc_min, o_busy
  );
endinterface

// File: rtl/watch_btn_sched.sv
// watch_btn_sched: debounces five raw buttons, queues adjust requests as
// pending flags and issues them as one-cycle increment pulses in priority
// nara > day > hour > min, never in a cycle where the second tick fires.
// Owns the time/alarm set-mode bit toggled by the mode button.
//
// Ports:
//   i_clk    : system clock
//   i_reset  : asynchronous, active-low reset
//   bus      : watch_btn_sched_if.slave (buttons, tick, set, inc_*, busy)
//
// Parameters: DEB_CYCLES (stable cycles to accept a level change),
//   REPEAT_DELAY / REPEAT_PERIOD (hour/min auto-repeat timing).
//
// Build option: define WATCH_AUTO_REPEAT_EN to add hour/min auto-repeat
// while the button stays held. Without it every press gives one pulse.

// Per-button lane: 2-flop synchronizer followed by a counter debouncer.
module wbs_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_db
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_db;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      // Any cycle agreeing with the accepted level restarts the count.
      if (r_sync[1] != r_db) begin
        if (r_cnt == LAST) begin
          r_db  <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db = r_db;
endmodule

module watch_btn_sched #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  watch_btn_sched_if.slave   bus
);
  localparam int NUM_BTN = 5;
  localparam int NUM_INC = 4;
  localparam int B_MODE  = 4;

  // Lane order: 0 nara, 1 day, 2 hour, 3 min, 4 mode.
  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_db;
  logic [NUM_BTN-1:0] r_db_d;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_INC-1:0] r_pend;
  logic [NUM_INC-1:0] w_pend_nxt;
  logic [NUM_INC-1:0] w_issue;
  logic [NUM_INC-1:0] w_press_acc;
  logic [NUM_INC-1:0] w_rpt_fire;
  logic [1:0]         w_rpt_lane;
  logic               r_set;
  logic               w_mode_ev;

  assign w_btn_raw = {bus.i_btn_mode, bus.i_btn_min, bus.i_btn_hour,
                      bus.i_btn_day, bus.i_btn_nara};

  wbs_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTN-1:0] (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (w_btn_raw),
    .o_db    (w_db)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_db_d <= '0;
    else          r_db_d <= w_db;
  end

  // Press = debounced rise; releases are ignored.
  assign w_press   = w_db & ~r_db_d;
  assign w_mode_ev = w_press[B_MODE];

  // In alarm-set mode nara/day presses are dropped outright.
  assign w_press_acc = w_press[NUM_INC-1:0] & {2'b11, ~r_set, ~r_set};

  // Lowest set bit is the highest priority flag; nothing issues on a tick.
  assign w_issue = bus.i_tick ? '0 : (r_pend & (~r_pend + 4'd1));

  assign w_rpt_fire = {w_rpt_lane, 2'b00};

  // A press landing on the issue cycle re-arms the flag, so one more pulse
  // follows. Mode clearing is applied after issue, so an hour/min pulse
  // issued on the mode edge still goes out under the old mode.
  always_comb begin
    w_pend_nxt = (r_pend & ~w_issue) | w_press_acc | w_rpt_fire;
    if (w_mode_ev) begin
      w_pend_nxt[3:2] = 2'b00;
      if (!r_set) w_pend_nxt[1:0] = 2'b00;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pend <= '0;
      r_set  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_set  <= r_set ^ w_mode_ev;
    end
  end

`ifdef WATCH_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  // Hour and min lanes only. The counter starts at 1 on the press edge so
  // it equals the number of cycles since the press event; the first fire
  // comes REPEAT_DELAY cycles after that event, then every REPEAT_PERIOD.
  for (genvar g = 0; g < 2; g++) begin : g_rpt
    localparam int L = 2 + g;
    logic [RW-1:0] r_cnt;
    logic          r_run;
    logic          r_arm;
    logic          w_last;

    assign w_last        = r_arm ? (r_cnt == RW'(REPEAT_PERIOD - 1))
                                 : (r_cnt == RW'(REPEAT_DELAY - 1));
    assign w_rpt_lane[g] = r_run & w_db[L] & w_last;

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_cnt <= '0;
        r_run <= 1'b0;
        r_arm <= 1'b0;
      end else if (w_mode_ev || !w_db[L]) begin
        r_cnt <= '0;
        r_run <= 1'b0;
        r_arm <= 1'b0;
      end else if (w_press[L]) begin
        r_cnt <= RW'(1);
        r_run <= 1'b1;
        r_arm <= 1'b0;
      end else if (r_run) begin
        if (w_last) begin
          r_cnt <= '0;
          r_arm <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign w_rpt_lane = 2'b00;
`endif

  assign bus.o_inc_nara = w_issue[0];
  assign bus.o_inc_day  = w_issue[1];
  assign bus.o_inc_hour = w_issue[2];
  assign bus.o_inc_min  = w_issue[3];
  assign bus.o_busy     = |r_pend;
  assign bus.o_set      = r_set;
endmodule

// File: tb/tb_watch_btn_sched.sv
// Bench for watch_btn_sched: a table of per-cycle vectors, hand-written
// corner sequences and a randomized phase, all cross-checked every cycle
// against a behavioural model of the button/pending/mode rules.
module tb_watch_btn_sched;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  localparam logic [4:0] B_NARA = 5'b00001;
  localparam logic [4:0] B_DAY  = 5'b00010;
  localparam logic [4:0] B_HOUR = 5'b00100;
  localparam logic [4:0] B_MIN  = 5'b01000;
  localparam logic [4:0] B_MODE = 5'b10000;
  localparam logic [4:0] B_ALL4 = 5'b01111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  watch_btn_sched_if bus();

  watch_btn_sched #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] obs;   // {set, busy, inc_min, inc_hour, inc_day, inc_nara}
  int pc[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_s1[5], m_s2[5], m_db[5], m_rose[5];
  int m_streak[5];
  bit m_pend[4];
  bit m_set;
  bit m_ract[4];
  int m_t0[4];
  int m_cyc;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_rose[i] = 0; m_streak[i] = 0;
    end
    for (int f = 0; f < 4; f++) begin
      m_pend[f] = 0; m_ract[f] = 0; m_t0[f] = 0;
    end
    m_set = 0;
  endtask

  function automatic logic [5:0] model_out(input logic t);
    logic [3:0] inc;
    bit found;
    inc = '0;
    found = 0;
    if (!t)
      for (int f = 0; f < 4; f++)
        if (m_pend[f] && !found) begin inc[f] = 1'b1; found = 1; end
    return {m_set, (m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3]), inc};
  endfunction

  task automatic model_edge(input logic [4:0] b, input logic t);
    int iss;
    int k;
    bit ev[5];
    bit fire[4];
    bit mev;
    bit nxt;
    iss = -1;
    if (!t)
      for (int f = 0; f < 4; f++) if (m_pend[f] && iss < 0) iss = f;
    for (int i = 0; i < 5; i++) ev[i] = m_rose[i];
    mev = ev[4];
    for (int f = 0; f < 4; f++) fire[f] = 0;
`ifdef WATCH_AUTO_REPEAT_EN
    for (int f = 2; f < 4; f++)
      if (m_ract[f] && m_db[f]) begin
        k = m_cyc - m_t0[f];
        if (k >= RD - 1 && (k - (RD - 1)) % RP == 0) fire[f] = 1;
      end
`else
    k = 0;
`endif
    for (int f = 0; f < 4; f++) begin
      nxt = m_pend[f] && (iss != f);
      if (ev[f] && !(f < 2 && m_set)) nxt = 1;
      if (fire[f]) nxt = 1;
      if (mev && f >= 2) nxt = 0;
      if (mev && !m_set && f < 2) nxt = 0;
      m_pend[f] = nxt;
    end
    for (int f = 2; f < 4; f++) begin
      if (mev) m_ract[f] = 0;
      else if (ev[f]) begin m_ract[f] = 1; m_t0[f] = m_cyc; end
      else if (!m_db[f]) m_ract[f] = 0;
    end
    if (mev) m_set = !m_set;
    for (int i = 0; i < 5; i++) begin
      m_rose[i] = 0;
      if (m_s2[i] != m_db[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DEB) begin
          m_db[i] = m_s2[i];
          m_streak[i] = 0;
          m_rose[i] = m_db[i];
        end
      end else begin
        m_streak[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = b[i];
    end
    m_cyc++;
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns later, then
  // advance the model on the rising edge.
  task automatic step(input logic [4:0] b, input logic t);
    @(negedge clk);
    {bus.i_btn_mode, bus.i_btn_min, bus.i_btn_hour, bus.i_btn_day, bus.i_btn_nara} = b;
    bus.i_tick = t;
    #1;
    obs = {bus.o_set, bus.o_busy, bus.o_inc_min, bus.o_inc_hour, bus.o_inc_day, bus.o_inc_nara};
    chk("model", {26'd0, obs}, {26'd0, model_out(t)});
    @(posedge clk);
    model_edge(b, t);
  endtask

  task automatic press(input logic [4:0] b, input logic t, input int hold, input int gap);
    for (int i = 0; i < 4; i++) pc[i] = 0;
    for (int r = 0; r < hold + gap; r++) begin
      step((r < hold) ? b : 5'b0, t);
      for (int i = 0; i < 4; i++) if (obs[i]) pc[i]++;
    end
  endtask

  typedef struct {
    logic [4:0] btn;
    logic       tick;
    logic [3:0] inc;
    logic       set;
    logic       busy;
  } vec_t;

  vec_t tbl[48];
  int   exp_rows[$];
  int   got_rows[$];
  int   hold[5];
  logic [4:0] rb;

  initial begin
    // ---------- vector table ----------
    for (int i = 0; i < 48; i++) tbl[i] = '{5'b0, 1'b0, 4'b0, 1'b0, 1'b0};
    // min held 10 cycles: one pulse 7 cycles after the rise
    for (int i = 0; i < 10; i++) tbl[i].btn = B_MIN;
    tbl[7].inc = 4'b1000; tbl[7].busy = 1'b1;
    // four buttons together, tick on the second issue cycle
    for (int i = 24; i < 34; i++) tbl[i].btn = B_ALL4;
    tbl[32].tick = 1'b1;
    tbl[31].inc = 4'b0001;
    tbl[33].inc = 4'b0010;
    tbl[34].inc = 4'b0100;
    tbl[35].inc = 4'b1000;
    for (int i = 31; i <= 35; i++) tbl[i].busy = 1'b1;

    // ---------- reset ----------
    {bus.i_btn_mode, bus.i_btn_min, bus.i_btn_hour, bus.i_btn_day, bus.i_btn_nara} = 5'b0;
    bus.i_tick = 1'b0;
    model_reset();
    m_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {26'd0, bus.o_set, bus.o_busy, bus.o_inc_min, bus.o_inc_hour,
                          bus.o_inc_day, bus.o_inc_nara}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 48; i++) begin
      step(tbl[i].btn, tbl[i].tick);
      chk($sformatf("vec%0d", i), {26'd0, obs}, {26'd0, tbl[i].set, tbl[i].busy, tbl[i].inc});
    end

    // ---------- bouncing hour: no pulse ----------
    for (int i = 0; i < 4; i++) pc[i] = 0;
    for (int i = 0; i < 12; i++) begin
      step(((i / 2) % 2 == 0) ? B_HOUR : 5'b0, 1'b0);
      if (obs[2]) pc[2]++;
    end
    press(5'b0, 1'b0, 0, 10);
    chk("bounce_no_hour", pc[2], 0);

    // ---------- four together, tick-free drain ----------
    for (int r = 0; r < 12; r++) begin
      step((r < 10) ? B_ALL4 : 5'b0, 1'b0);
      if (r >= 7 && r <= 10) chk($sformatf("drain%0d", r - 7), {28'd0, obs[3:0]}, 32'd1 << (r - 7));
      if (r == 11) chk("drain_done", {26'd0, obs}, 32'd0);
    end
    press(5'b0, 1'b0, 0, 12);

    // ---------- mode handling ----------
    press(B_MODE, 1'b0, 8, 12);
    chk("mode_set1", obs[5], 1'b1);
    press(B_DAY, 1'b0, 8, 12);
    chk("alarm_day_dropped", pc[1], 0);
    press(B_MIN, 1'b0, 8, 12);
    chk("alarm_min_pulse", pc[3], 1);
    press(B_MODE, 1'b0, 8, 12);
    chk("mode_set0", obs[5], 1'b0);

    // ---------- hour queued under tick, then mode press ----------
    press(B_HOUR, 1'b1, 8, 4);
    chk("hour_held_by_tick", {31'd0, obs[4]}, 32'd1);
    chk("no_inc_in_tick", {28'd0, obs[3:0]}, 32'd0);
    press(B_MODE, 1'b1, 8, 12);
    chk("mode_cleared_hour", {30'd0, obs[5:4]}, 32'b10);
    press(5'b0, 1'b0, 0, 12);
    chk("no_hour_after_tick", pc[2], 0);
    press(B_MODE, 1'b0, 8, 12);
    chk("mode_back0", obs[5], 1'b0);

    // ---------- long hold on min ----------
    // Press event 2+DEB cycles after the rise; first pulse one cycle later.
    // Repeats can still fire up to the cycle where db falls (release+2+DEB).
    exp_rows.push_back(2 + DEB + 1);
`ifdef WATCH_AUTO_REPEAT_EN
    for (int r = 2 + DEB + RD; r <= 60 + 2 + DEB; r += RP) exp_rows.push_back(r);
`endif
    for (int r = 0; r < 80; r++) begin
      step((r < 60) ? B_MIN : 5'b0, 1'b0);
      if (obs[3]) got_rows.push_back(r);
    end
    chk("hold_pulse_count", got_rows.size(), exp_rows.size());
    for (int i = 0; i < exp_rows.size() && i < got_rows.size(); i++)
      chk($sformatf("hold_pulse%0d", i), got_rows[i], exp_rows[i]);

    // ---------- randomized, with a reset in the middle ----------
    for (int i = 0; i < 5; i++) hold[i] = 0;
    rb = '0;
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < 5; i++) begin
          if (hold[i] == 0) begin
            rb[i] = 1'($urandom_range(0, 1));
            hold[i] = (i == 4 && !rb[i]) ? $urandom_range(10, 60) : $urandom_range(1, 30);
          end else begin
            hold[i]--;
          end
        end
        step(rb, ($urandom_range(0, 7) == 0));
      end
      if (phase == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset", {26'd0, bus.o_set, bus.o_busy, bus.o_inc_min, bus.o_inc_hour,
                             bus.o_inc_day, bus.o_inc_nara}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
